channel_arbiter: RTL and testbench
==================================

// Module: channel_arbiter
// PURPOSE
//  Round-robin merge of COUNT set/get channel streams into one output channel.
//  A transfer happens on a rising clk edge when both xx_set and xx_get are high.
//  The output is a single registered stage and tags each word with its source index.
//  Sits in front of a shared consumer, e.g. a single UART TX or a shared bus port.
// PARAMETERS
//  WIDTH  8  data bits per word
//  COUNT  4  number of input streams, 2..16
//  SRC_W  = $clog2(COUNT), localparam: width of the source index
// PORTS
//  clk      in   1            rising-edge clock
//  rst      in   1            synchronous reset, active-high
//  in_dat   in   COUNT*WIDTH  word of input i on bits [i*WIDTH +: WIDTH]
//  in_set   in   COUNT        input i offers a word
//  in_get   out  COUNT        arbiter accepts the word of input i (at most one bit high)
//  out_dat  out  WIDTH        registered output word
//  out_src  out  SRC_W        index of the input that supplied out_dat
//  out_set  out  1            out_dat/out_src valid
//  out_get  in   1            consumer accepts the output word
// BEHAVIOUR
//  - Reset: out_set=0, out_dat=0, out_src=0, in_get=0, ptr=COUNT-1 (input 0 has top priority), lock=0.
//  - free = !out_set || out_get. This is combinational, same cycle.
//  - win = first i with in_set[i], searching from (ptr+1) mod COUNT upward and wrapping.
//  - in_get[i] = !rst && free && any(in_set) && (i == win). It is combinational from in_set, out_get and state.
//    Consequently in_get is one-hot or all-zero.
//  - On an edge with free && any(in_set):
//    - out_dat <= in_dat[win], out_src <= win, out_set <= 1, ptr <= win.
//  - On an edge with free && no in_set: out_set <= 0. out_dat and out_src hold their values.
//  - On an edge with !free: all registers hold.
//  - Latency: 1 cycle from input transfer to out_set.
//  - Throughput: 1 word/cycle when out_get stays high.
//  - Fairness: after input k is served, every other requesting input is served before k again.
//    Steady max wait is COUNT-1 grants.
//  - ptr advances only on a transfer. An idle cycle does not rotate priority.
//  - ptr wrap-around: ptr=COUNT-1 makes the search start at 0.
//  - An input that drops in_set while not granted loses nothing. The next winner is re-evaluated each cycle.
//  - Back-pressure (out_set=1, out_get=0): in_get=0, and out_dat/out_src are stable until accepted.
//  - rst asserted mid-operation: any held output word is discarded. No input word is accepted in that cycle.
// CONFIGURATION
//  - Macro CHANNEL_ARBITER_LOCK_EN. When defined, it adds packet locking:
//    - New ports: in_lst in COUNT (last-word flag per input) and out_lst out 1 (registered with out_dat).
//    - out_lst resets to 0.
//    - When a word with in_lst[win]=0 transfers: lock<=1, and win is held as the locked source in ptr.
//    - While lock=1: win = ptr. Only in_get[ptr] may go high, and other inputs wait even if requesting.
//    - When a word with in_lst=1 transfers: lock<=0, and normal round-robin resumes from ptr+1.
//    - A single-word packet (in_lst=1) never sets lock.
//  - Macro undefined: no in_lst/out_lst ports, no lock state. Arbitration is strictly per word.
// TESTING
//  1. rst=1 for 2 cycles, with in_set=4'b1111 -> in_get=0 and out_set=0.
//     After release: first grant goes to input 0, then 1, 2, 3, 0 with out_get=1.
//  2. in_set=4'b0101, out_get=1 constant -> out_src sequence 0,2,0,2.
//     out_dat matches each input's word. One word per cycle.
//  3. out_get=0 with a word held (dat=8'hA5, src=1) for 5 cycles -> out_dat/out_src/out_set stable, in_get=0.
//     Raise out_get -> the next winner is accepted in the same cycle.
//  4. Only input 3 requests, then only input 0 -> out_src 3 then 0.
//     This checks ptr wrap-around and that idle cycles do not rotate ptr.
//  5. Assert rst while out_set=1 and out_get=0 -> out_set=0 on the next edge, and no in_get pulse during rst.
//  6. With CHANNEL_ARBITER_LOCK_EN, input 1 sends 3 words (lst=0,0,1) while input 2 requests continuously.
//     Required: out_src=1,1,1, then 2. out_lst=0,0,1.

Source files
------------

// File: rtl/channel_arbiter_if.sv
// Handshake bundle between COUNT producer streams, the arbiter and the shared consumer.
// Packet-lock sideband signals exist only when CHANNEL_ARBITER_LOCK_EN is defined.
interface channel_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int COUNT = 4
);
   localparam int SRC_W = $clog2(COUNT);

   logic [COUNT*WIDTH-1:0] in_dat;
   logic [COUNT-1:0]       in_set;
   logic [COUNT-1:0]       in_get;
   logic [WIDTH-1:0]       out_dat;
   logic [SRC_W-1:0]       out_src;
   logic                   out_set;
   logic                   out_get;
`ifdef CHANNEL_ARBITER_LOCK_EN
   logic [COUNT-1:0]       in_lst;
   logic                   out_lst;

   modport master (
      output in_dat, in_set, in_lst, out_get,
      input  in_get, out_dat, out_src, out_set, out_lst
   );
   modport slave (
      input  in_dat, in_set, in_lst, out_get,
      output in_get, out_dat, out_src, out_set, out_lst
   );
`else
   modport master (
      output in_dat, in_set, out_get,
      input  in_get, out_dat, out_src, out_set
   );
   modport slave (
      input  in_dat, in_set, out_get,
      output in_get, out_dat, out_src, out_set
   );
`endif
endinterface

// File: rtl/channel_arbiter.sv
// Round-robin merge of COUNT set/get streams into one registered, source-tagged output.
// Define CHANNEL_ARBITER_LOCK_EN to hold the grant on one input until its last word.
module channel_arbiter #(
   parameter int WIDTH = 8,
   parameter int COUNT = 4
) (
   input logic               clk,
   input logic               rst,
   channel_arbiter_if.slave  bus
);
   localparam int SRC_W = $clog2(COUNT);

   logic [WIDTH-1:0] dat_arr [COUNT];

   logic [WIDTH-1:0] out_dat_reg, out_dat_next;
   logic [SRC_W-1:0] out_src_reg, out_src_next;
   logic             out_set_reg, out_set_next;
   logic [SRC_W-1:0] ptr_reg, ptr_next;
`ifdef CHANNEL_ARBITER_LOCK_EN
   logic             lock_reg, lock_next;
   logic             out_lst_reg, out_lst_next;
`endif

   logic [SRC_W-1:0] win;
   logic             found;
   logic             free;
   logic             grant;

   genvar gi;
   generate
      for (gi = 0; gi < COUNT; gi++) begin : g_unpack
         assign dat_arr[gi] = bus.in_dat[gi*WIDTH +: WIDTH];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         out_dat_reg <= '0;
         out_src_reg <= '0;
         out_set_reg <= 1'b0;
         ptr_reg     <= SRC_W'(COUNT - 1);
`ifdef CHANNEL_ARBITER_LOCK_EN
         lock_reg    <= 1'b0;
         out_lst_reg <= 1'b0;
`endif
      end else begin
         out_dat_reg <= out_dat_next;
         out_src_reg <= out_src_next;
         out_set_reg <= out_set_next;
         ptr_reg     <= ptr_next;
`ifdef CHANNEL_ARBITER_LOCK_EN
         lock_reg    <= lock_next;
         out_lst_reg <= out_lst_next;
`endif
      end
   end

   // Winner search starts just past the last served input and wraps once around.
   always_comb begin
      logic [SRC_W-1:0] cand;
      win   = ptr_reg;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= COUNT; k++) begin
         cand = SRC_W'((int'(ptr_reg) + k) % COUNT);
         if (!found && bus.in_set[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
`ifdef CHANNEL_ARBITER_LOCK_EN
      // Mid-packet, only the locked source may transfer; others keep waiting.
      if (lock_reg) begin
         win   = ptr_reg;
         found = bus.in_set[ptr_reg];
      end
`endif
      free  = !out_set_reg || bus.out_get;
      grant = !rst && free && found;

      out_dat_next = out_dat_reg;
      out_src_next = out_src_reg;
      out_set_next = out_set_reg;
      ptr_next     = ptr_reg;
`ifdef CHANNEL_ARBITER_LOCK_EN
      lock_next    = lock_reg;
      out_lst_next = out_lst_reg;
`endif
      if (grant) begin
         out_dat_next = dat_arr[win];
         out_src_next = win;
         out_set_next = 1'b1;
         ptr_next     = win;
`ifdef CHANNEL_ARBITER_LOCK_EN
         lock_next    = !bus.in_lst[win];
         out_lst_next = bus.in_lst[win];
`endif
      end else if (free) begin
         out_set_next = 1'b0;
      end
   end

   always_comb begin
      bus.in_get = '0;
      if (grant) begin
         bus.in_get[win] = 1'b1;
      end
   end

   assign bus.out_dat = out_dat_reg;
   assign bus.out_src = out_src_reg;
   assign bus.out_set = out_set_reg;
`ifdef CHANNEL_ARBITER_LOCK_EN
   assign bus.out_lst = out_lst_reg;
`endif
endmodule

// File: tb/tb_channel_arbiter.sv
// Self-checking bench for channel_arbiter: vector table, directed corner sequences,
// then randomized traffic against a priority-list reference model.
module tb_channel_arbiter;
   localparam int WIDTH = 8;
   localparam int COUNT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   channel_arbiter_if #(.WIDTH(WIDTH), .COUNT(COUNT)) bus ();

   channel_arbiter #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] set;
      logic       og;
      logic [3:0] exp_get;
      logic       exp_set;
      logic [1:0] exp_src;
   } vec_t;

   vec_t vecs [15];

   // Reference model: front of prio holds the highest-priority input.
   int         prio [$];
   logic       m_set;
   logic [7:0] m_dat;
   logic [1:0] m_src;
   logic       m_lst;
   logic       m_locked;
   int         m_lock_src;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      prio = {0, 1, 2, 3};
      m_set = 1'b0;
      m_dat = '0;
      m_src = '0;
      m_lst = 1'b0;
      m_locked = 1'b0;
      m_lock_src = 0;
   endtask

   function automatic int model_win(input logic [3:0] set);
      if (m_locked) return set[m_lock_src] ? m_lock_src : -1;
      foreach (prio[j]) if (set[prio[j]]) return prio[j];
      return -1;
   endfunction

   task automatic model_grant(input int w, input logic [31:0] dat, input logic lst);
      int p;
      m_dat = dat[w*8 +: 8];
      m_src = 2'(w);
      m_set = 1'b1;
      m_lst = lst;
      m_locked = !lst;
      m_lock_src = w;
      while (prio[$] != w) begin
         p = prio.pop_front();
         prio.push_back(p);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{4'hf, 1'b1, 4'b0001, 1'b1, 2'd0};
      vecs[1]  = '{4'hf, 1'b1, 4'b0010, 1'b1, 2'd1};
      vecs[2]  = '{4'hf, 1'b1, 4'b0100, 1'b1, 2'd2};
      vecs[3]  = '{4'hf, 1'b1, 4'b1000, 1'b1, 2'd3};
      vecs[4]  = '{4'hf, 1'b1, 4'b0001, 1'b1, 2'd0};
      vecs[5]  = '{4'h8, 1'b1, 4'b1000, 1'b1, 2'd3};
      vecs[6]  = '{4'h5, 1'b1, 4'b0001, 1'b1, 2'd0};
      vecs[7]  = '{4'h5, 1'b1, 4'b0100, 1'b1, 2'd2};
      vecs[8]  = '{4'h5, 1'b1, 4'b0001, 1'b1, 2'd0};
      vecs[9]  = '{4'h5, 1'b1, 4'b0100, 1'b1, 2'd2};
      vecs[10] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd2};
      vecs[11] = '{4'h8, 1'b1, 4'b1000, 1'b1, 2'd3};
      vecs[12] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd3};
      vecs[13] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd3};
      vecs[14] = '{4'h1, 1'b1, 4'b0001, 1'b1, 2'd0};

      for (int i = 0; i < COUNT; i++) bus.in_dat[i*8 +: 8] = 8'(8'h10 + i);
      bus.in_set  = 4'hf;
      bus.out_get = 1'b1;
`ifdef CHANNEL_ARBITER_LOCK_EN
      bus.in_lst  = 4'hf;
`endif

      // Reset held for two cycles with every input requesting.
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("rst%0d in_get", c), 32'(bus.in_get), 32'h0);
         @(posedge clk); #1;
         chk($sformatf("rst%0d out_set", c), 32'(bus.out_set), 32'h0);
      end
      chk("rst out_dat", 32'(bus.out_dat), 32'h0);
      chk("rst out_src", 32'(bus.out_src), 32'h0);
      rst = 1'b0;

      for (int v = 0; v < 15; v++) begin
         bus.in_set  = vecs[v].set;
         bus.out_get = vecs[v].og;
         #1;
         chk($sformatf("vec%0d in_get", v), 32'(bus.in_get), 32'(vecs[v].exp_get));
         @(posedge clk); #1;
         chk($sformatf("vec%0d out_set", v), 32'(bus.out_set), 32'(vecs[v].exp_set));
         chk($sformatf("vec%0d out_src", v), 32'(bus.out_src), 32'(vecs[v].exp_src));
         if (vecs[v].exp_set)
            chk($sformatf("vec%0d out_dat", v), 32'(bus.out_dat), 32'(8'h10 + vecs[v].exp_src));
      end

      // Back-pressure: held word stays put, no input accepted.
      bus.in_dat[15:8] = 8'hA5;
      bus.in_set  = 4'b0010;
      bus.out_get = 1'b1;
      #1;
      chk("bp load in_get", 32'(bus.in_get), 32'b0010);
      @(posedge clk); #1;
      bus.in_set  = 4'hf;
      bus.out_get = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp%0d in_get", c), 32'(bus.in_get), 32'h0);
         @(posedge clk); #1;
         chk($sformatf("bp%0d out_dat", c), 32'(bus.out_dat), 32'hA5);
         chk($sformatf("bp%0d out_src", c), 32'(bus.out_src), 32'd1);
         chk($sformatf("bp%0d out_set", c), 32'(bus.out_set), 32'd1);
      end
      bus.out_get = 1'b1;
      #1;
      chk("bp release in_get", 32'(bus.in_get), 32'b0100);
      @(posedge clk); #1;
      chk("bp release out_src", 32'(bus.out_src), 32'd2);
      chk("bp release out_dat", 32'(bus.out_dat), 32'h12);

      // Reset while a word is held under back-pressure.
      bus.out_get = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst in_get", 32'(bus.in_get), 32'h0);
      @(posedge clk); #1;
      chk("midrst out_set", 32'(bus.out_set), 32'h0);
      chk("midrst out_dat", 32'(bus.out_dat), 32'h0);
      chk("midrst in_get2", 32'(bus.in_get), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.out_get = 1'b1;

`ifdef CHANNEL_ARBITER_LOCK_EN
      // Input 1 sends a 3-word packet while input 2 keeps requesting.
      begin
         logic [2:0] lst_seq;
         logic [3:0] get_seq [4];
         logic [1:0] src_seq [4];
         logic [3:0] olst_seq;
         lst_seq  = 3'b100;
         olst_seq = 4'b1100;
         get_seq  = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
         src_seq  = '{2'd1, 2'd1, 2'd1, 2'd2};
         bus.in_set = 4'b0110;
         for (int c = 0; c < 4; c++) begin
            bus.in_lst = (c < 3) ? {2'b11, lst_seq[c], 1'b1} : 4'hf;
            #1;
            chk($sformatf("lock%0d in_get", c), 32'(bus.in_get), 32'(get_seq[c]));
            @(posedge clk); #1;
            chk($sformatf("lock%0d out_src", c), 32'(bus.out_src), 32'(src_seq[c]));
            chk($sformatf("lock%0d out_lst", c), 32'(bus.out_lst), 32'(olst_seq[c]));
         end
      end
`endif

      // Randomized traffic against the reference model.
      rst = 1'b1;
      bus.in_set = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 400; c++) begin
         int         w;
         logic       free;
         logic [3:0] lst;
         bus.in_set  = 4'($urandom);
         bus.in_dat  = $urandom;
         bus.out_get = ($urandom_range(0, 3) != 0);
         lst = 4'hf;
`ifdef CHANNEL_ARBITER_LOCK_EN
         lst = 4'($urandom);
         bus.in_lst = lst;
`endif
         #1;
         free = !m_set || bus.out_get;
         w = free ? model_win(bus.in_set) : -1;
         chk($sformatf("rnd%0d in_get", c), 32'(bus.in_get), (w >= 0) ? (32'd1 << w) : 32'd0);
         if (w >= 0) model_grant(w, bus.in_dat, lst[w]);
         else if (free) m_set = 1'b0;
         @(posedge clk); #1;
         chk($sformatf("rnd%0d out_set", c), 32'(bus.out_set), 32'(m_set));
         chk($sformatf("rnd%0d out_src", c), 32'(bus.out_src), 32'(m_src));
         chk($sformatf("rnd%0d out_dat", c), 32'(bus.out_dat), 32'(m_dat));
`ifdef CHANNEL_ARBITER_LOCK_EN
         chk($sformatf("rnd%0d out_lst", c), 32'(bus.out_lst), 32'(m_lst));
`endif
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
